// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the occupancy-counter width helper.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF     = 45;
    localparam int FIFO_DEPTH_DEF     = 32;
    localparam int FIFO_AF_MARGIN_DEF = 4;

    // The counter must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, asynchronous read; write visible on rdata after the edge.
// No flow control here; the owner gates we.
module fifo_mem #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/push_stop_fifo.sv
// First-word fall-through FIFO with push/stop handshakes; write-to-dout latency 1 cycle, no read bubble.
// stopin is raised only when full; offers made while full are dropped and flagged in sticky overflow.
module push_stop_fifo
    import fifo_pkg::*;
#(
    parameter  int WIDTH    = FIFO_WIDTH_DEF,
    parameter  int DEPTH    = FIFO_DEPTH_DEF,
    parameter  int AF_LEVEL = DEPTH - FIFO_AF_MARGIN_DEF,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = fifo_cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushin,
    input  logic [WIDTH-1:0] din,
    output logic             stopin,
    output logic             pushout,
    input  logic             stopout,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             overflow
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_en;
    logic          rd_en;

    // Flags come from the count register alone, so no input reaches them combinationally.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AF_LEVEL));
    assign stopin      = full;
    assign pushout     = !empty;

    assign wr_en = pushin && !full && !reset;
    assign rd_en = pushout && !stopout && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so natural rollover is the modulo wrap.
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pushin && full) begin
                overflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wptr),
        .wdata(din),
        .raddr(rptr),
        .rdata(dout)
    );

endmodule

// File: tb/tb_push_stop_fifo.sv
// Self-checking bench for push_stop_fifo: directed table, corner sequences, and randomized traffic vs a queue model.
module tb_push_stop_fifo;

    localparam int W  = 45;
    localparam int D  = 32;
    localparam int AF = 28;

    logic          clk = 1'b0;
    logic          reset;
    logic          pushin;
    logic [W-1:0]  din;
    logic          stopin;
    logic          pushout;
    logic          stopout;
    logic [W-1:0]  dout;
    logic [5:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mq[$];
    bit           movf;

    always #5 clk = ~clk;

    push_stop_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .pushin     (pushin),
        .din        (din),
        .stopin     (stopin),
        .pushout    (pushout),
        .stopout    (stopout),
        .dout       (dout),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .overflow   (overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ":count"}, 64'(count), 64'(n));
        chk({tag, ":empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ":full"}, 64'(full), 64'(n == D));
        chk({tag, ":stopin"}, 64'(stopin), 64'(n == D));
        chk({tag, ":almost_full"}, 64'(almost_full), 64'(n >= AF));
        chk({tag, ":pushout"}, 64'(pushout), 64'(n != 0));
        chk({tag, ":overflow"}, 64'(overflow), 64'(movf));
        if (n != 0) chk({tag, ":dout"}, 64'(dout), 64'(mq[0]));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input bit r, input bit p, input logic [W-1:0] d, input bit s, input string tag);
        bit was_full;
        bit was_empty;
        reset = r; pushin = p; din = d; stopout = s;
        @(posedge clk);
        if (r) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            was_full  = (mq.size() == D);
            was_empty = (mq.size() == 0);
            if (p && was_full) movf = 1'b1;
            if (!was_empty && !s) void'(mq.pop_front());
            if (p && !was_full) mq.push_back(d);
        end
        #1;
        chk_model(tag);
    endtask

    typedef struct {
        bit           rst;
        bit           push;
        logic [W-1:0] d;
        bit           stop;
        int           cnt;
        bit           pv;
        logic [W-1:0] dq;
    } vec_t;

    vec_t tbl[11];

    logic [W-1:0] in_seq[$];
    logic [W-1:0] out_seq[$];

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    initial begin
        reset = 1'b1; pushin = 1'b0; din = '0; stopout = 1'b1;
        movf = 1'b0;

        // rst push din stop | count pushout dout
        tbl[0]  = '{1, 0, 45'h0, 1, 0, 0, 45'h0};
        tbl[1]  = '{0, 0, 45'h0, 0, 0, 0, 45'h0};
        tbl[2]  = '{0, 1, 45'h1, 1, 1, 1, 45'h1};
        tbl[3]  = '{0, 1, 45'h2, 1, 2, 1, 45'h1};
        tbl[4]  = '{0, 1, 45'h3, 1, 3, 1, 45'h1};
        tbl[5]  = '{0, 0, 45'h0, 0, 2, 1, 45'h2};
        tbl[6]  = '{0, 0, 45'h0, 0, 1, 1, 45'h3};
        tbl[7]  = '{0, 0, 45'h0, 0, 0, 0, 45'h0};
        tbl[8]  = '{0, 0, 45'h0, 0, 0, 0, 45'h0};
        tbl[9]  = '{0, 1, 45'h7, 0, 1, 1, 45'h7};
        tbl[10] = '{0, 0, 45'h0, 0, 0, 0, 45'h0};

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].rst, tbl[i].push, tbl[i].d, tbl[i].stop, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d:exp_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d:exp_pushout", i), 64'(pushout), 64'(tbl[i].pv));
            chk($sformatf("tbl%0d:exp_empty", i), 64'(empty), 64'(tbl[i].cnt == 0));
            if (tbl[i].pv) chk($sformatf("tbl%0d:exp_dout", i), 64'(dout), 64'(tbl[i].dq));
        end

        // Fill to full with the reader stalled; watch almost_full and full thresholds.
        cycle(1, 0, '0, 1, "fill_rst");
        for (int i = 0; i < D; i++) begin
            cycle(0, 1, W'(100 + i), 1, "fill");
            chk("fill:af_thresh", 64'(almost_full), 64'((i + 1) >= 28));
            chk("fill:full_thresh", 64'(full), 64'((i + 1) == 32));
        end
        chk("fill:stopin_full", 64'(stopin), 64'(1));
        cycle(0, 1, W'(999), 1, "ovf_push");
        chk("ovf:overflow_set", 64'(overflow), 64'(1));
        chk("ovf:count_held", 64'(count), 64'(32));

        // Full with a simultaneous push and pop: only the read happens.
        cycle(0, 1, W'(777), 0, "full_pushpop");
        chk("full_pushpop:count", 64'(count), 64'(31));
        chk("full_pushpop:dout", 64'(dout), 64'(101));

        // Drain to 17, then reset mid-stream with inputs active.
        for (int i = 0; i < 14; i++) cycle(0, 0, '0, 0, "drain");
        chk("drain:count17", 64'(count), 64'(17));
        cycle(1, 1, W'(555), 0, "mid_rst");
        chk("mid_rst:count", 64'(count), 64'(0));
        chk("mid_rst:empty", 64'(empty), 64'(1));
        chk("mid_rst:overflow_clr", 64'(overflow), 64'(0));
        cycle(0, 1, W'(12'hABC), 1, "post_rst_push");
        chk("post_rst:dout_abc", 64'(dout), 64'(12'hABC));
        chk("post_rst:pushout", 64'(pushout), 64'(1));

        // Steady occupancy of 10 with continuous push/pop, crossing several pointer wraps.
        cycle(1, 0, '0, 1, "steady_rst");
        for (int i = 0; i < 10; i++) begin
            in_seq.push_back(rnd_word());
            cycle(0, 1, in_seq[$], 1, "steady_fill");
        end
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] w;
            w = rnd_word();
            in_seq.push_back(w);
            if (pushout) out_seq.push_back(dout);
            cycle(0, 1, w, 0, "steady");
            chk("steady:count10", 64'(count), 64'(10));
        end
        chk("steady:n_out", 64'(out_seq.size()), 64'(100));
        for (int i = 0; i < 100 && i < out_seq.size(); i++) begin
            chk($sformatf("steady:order%0d", i), 64'(out_seq[i]), 64'(in_seq[i]));
        end

        // Randomized traffic with phases biased toward filling and draining.
        cycle(1, 0, '0, 1, "rand_rst");
        for (int i = 0; i < 3000; i++) begin
            int pp;
            int ps;
            bit r;
            pp = ((i / 300) % 2 == 0) ? 80 : 30;
            ps = ((i / 300) % 2 == 0) ? 70 : 20;
            r  = ($urandom_range(0, 399) == 0);
            cycle(r, $urandom_range(0, 99) < pp, rnd_word(), $urandom_range(0, 99) < ps, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/push_stop_fifo.md
PUSH_STOP_FIFO -- requirements
Module: push_stop_fifo

Interface
REQ-001 Parameter WIDTH, default 45, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of entries; power of two, >= 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 pushin  input  1  upstream offers din this cycle.
REQ-007 din  input  WIDTH  write data, sampled when pushin && !stopin.
REQ-008 stopin  output  1  back-pressure to upstream; high = write refused.
REQ-009 pushout  output  1  dout holds valid head-of-queue data.
REQ-010 stopout  input  1  downstream refuses data; high = no read.
REQ-011 dout  output  WIDTH  head-of-queue data (first-word fall-through).
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 full, empty, almost_full  output  1 each  occupancy flags.
REQ-014 overflow  output  1  sticky: a push was offered while stopin was high.

Function
REQ-015 Write occurs when pushin && !stopin; din is stored at wptr, wptr increments modulo DEPTH.
REQ-016 Read occurs when pushout && !stopout; rptr increments modulo DEPTH.
REQ-017 pushout = !empty; dout = mem[rptr]; no read bubble.
REQ-018 Write-to-dout latency is 1 cycle: a word written into an empty FIFO at edge N appears on dout with pushout=1 after edge N.
REQ-019 stopin = full; a push and a pop in the same cycle while full is refused on the write side (no write-through).
REQ-020 Simultaneous write and read when not full and not empty: count unchanged; both pointers advance.
REQ-021 Read while empty is impossible (pushout=0); stopout is ignored while empty.
REQ-022 count increments on write only, decrements on read only, holds otherwise; never exceeds DEPTH, never goes below 0.
REQ-023 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); all flags derive from registered state only, with no combinational path from pushin/stopout.
REQ-024 overflow sets on any cycle with pushin && stopin and stays set until reset; the offered word is discarded.
REQ-025 Pointers are $clog2(DEPTH) bits; wrap from DEPTH-1 to 0 occurs without data loss or flag glitch.
REQ-026 Ordering is strict FIFO; every accepted word is delivered exactly once.

Reset
REQ-027 While reset is high at a clock edge: count=0, wptr=rptr=0, empty=1, full=0, almost_full=0, pushout=0, stopin=0, overflow=0.
REQ-028 Reset mid-operation discards all stored words; pushin and stopout are ignored on the reset cycle.
REQ-029 Storage array contents are not reset; dout is don't-care while pushout=0.

Structure
REQ-030 Package fifo_pkg holds FIFO_WIDTH_DEF=45, FIFO_DEPTH_DEF=32, FIFO_AF_MARGIN_DEF=4, and a count-width helper function.
REQ-031 Storage is a sub-module fifo_mem: one write port (we, waddr, wdata), one asynchronous read port (raddr, rdata), parametrised WIDTH/DEPTH.
REQ-032 Pointer, count, and flag logic reside in push_stop_fifo; no latches and no @(posedge) inside combinational blocks.

Verification
REQ-033 Reset then idle: count=0, empty=1, pushout=0, stopin=0, overflow=0.
REQ-034 Push 0x1, 0x2, 0x3 with stopout=1, then release stopout: dout reads 0x1, 0x2, 0x3 on consecutive cycles; empty=1 after the third read.
REQ-035 Push 32 words with stopout=1 (DEPTH=32): almost_full rises at count=28; full=stopin=1 at count=32; a 33rd push sets overflow and count stays 32.
REQ-036 With full, assert pushin and drop stopout in the same cycle: one read occurs, the write is refused, and count=31.
REQ-037 Hold count=10 with continuous push and pop for 100 cycles across a pointer wrap: count stays 10; output sequence equals input sequence.
REQ-038 Assert reset at count=17 mid-stream: on the next cycle count=0, empty=1, and overflow is cleared; a following push of 0xABC appears on dout one cycle later.
